// File: rtl/lz77_pkg.sv
// Shared LZ77 link constants and state encoding, used by both encoder and decoder.
package lz77_pkg;

  localparam int SB_DEPTH = 9;
  localparam int CHAR_W   = 8;
  localparam int POS_W    = 4;
  localparam int LEN_W    = 3;

  localparam logic [CHAR_W-1:0] EOF_CHAR = 8'h24;
  localparam logic [CHAR_W-1:0] SB_INIT  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } lz77_state_e;

  // Offsets beyond the oldest entry are pinned to the oldest entry.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos);
    if (pos > POS_W'(SB_DEPTH - 1)) begin
      return POS_W'(SB_DEPTH - 1);
    end else begin
      return pos;
    end
  endfunction

endpackage

// File: rtl/lz77_search_buf.sv
// Search buffer: shift register of recently emitted characters, newest at the top index,
// with a combinational read port addressed by offset from the newest entry.
module lz77_search_buf
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [CHAR_W-1:0] shift_data,
  input  logic [POS_W-1:0]  pos,
  output logic [CHAR_W-1:0] rd_data
);

  logic [CHAR_W-1:0] sb_r [SB_DEPTH];
  logic [POS_W-1:0]  idx_s;

  // Shift a new character in at the newest end; the oldest one falls off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_r[i] <= SB_INIT;
      end
    end else if (shift_en) begin
      for (int i = 0; i < SB_DEPTH - 1; i++) begin
        sb_r[i] <= sb_r[i+1];
      end
      sb_r[SB_DEPTH-1] <= shift_data;
    end
  end

  // Offset 0 addresses the newest entry; out-of-range offsets read the oldest.
  always_comb begin
    if (pos > POS_W'(SB_DEPTH - 1)) begin
      idx_s = POS_W'(0);
    end else begin
      idx_s = POS_W'(SB_DEPTH - 1) - pos;
    end
    rd_data = sb_r[idx_s];
  end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, length, literal) triples into a byte stream.
// Optional LZ77_DEC_CHK_EN adds a sticky err output for offsets that reach past the history.
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  code_pos,
  input  logic [LEN_W-1:0]  code_len,
  input  logic [CHAR_W-1:0] chardata,
  output logic              out_valid,
  output logic [CHAR_W-1:0] char_nxt,
  output logic              encode,
  output logic              finish
`ifdef LZ77_DEC_CHK_EN
  ,
  output logic              err
`endif
);

  lz77_state_e       state_r;
  logic [POS_W-1:0]  pos_r;
  logic [LEN_W-1:0]  rem_r;
  logic [CHAR_W-1:0] lit_r;
  logic [CHAR_W-1:0] sb_rd_s;
  logic [CHAR_W-1:0] shift_data_s;
  logic              shift_en_s;
  logic              accept_s;

  assign encode   = 1'b0;
  assign in_ready = (state_r == IDLE) && !reset;
  assign accept_s = in_ready && in_valid;

  lz77_search_buf u_sb (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (shift_en_s),
    .shift_data (shift_data_s),
    .pos        (pos_r),
    .rd_data    (sb_rd_s)
  );

  // Every emitted character, copied or literal, is also pushed into the history.
  always_comb begin
    shift_en_s   = 1'b0;
    shift_data_s = lit_r;
    case (state_r)
      COPY: begin
        shift_en_s   = 1'b1;
        shift_data_s = sb_rd_s;
      end
      LIT: begin
        shift_en_s   = 1'b1;
        shift_data_s = lit_r;
      end
      default: begin
        shift_en_s   = 1'b0;
        shift_data_s = lit_r;
      end
    endcase
  end

  // Triple sequencing FSM with registered character output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      pos_r     <= POS_W'(0);
      rem_r     <= LEN_W'(0);
      lit_r     <= CHAR_W'(0);
      out_valid <= 1'b0;
      char_nxt  <= CHAR_W'(0);
      finish    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          if (accept_s) begin
            pos_r   <= clamp_pos(code_pos);
            rem_r   <= code_len;
            lit_r   <= chardata;
            state_r <= (code_len != LEN_W'(0)) ? COPY : LIT;
          end
        end
        COPY: begin
          char_nxt  <= sb_rd_s;
          out_valid <= 1'b1;
          rem_r     <= rem_r - LEN_W'(1);
          if (rem_r == LEN_W'(1)) begin
            state_r <= LIT;
          end
        end
        LIT: begin
          char_nxt  <= lit_r;
          out_valid <= 1'b1;
          if (lit_r == EOF_CHAR) begin
            finish  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= IDLE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

`ifdef LZ77_DEC_CHK_EN
  logic [POS_W-1:0] fill_r;
  logic             bad_ref_s;

  // A copy may only reference characters that were actually emitted since reset.
  always_comb begin
    if (code_pos > POS_W'(SB_DEPTH - 1)) begin
      bad_ref_s = 1'b1;
    end else if ((code_len != LEN_W'(0)) && (code_pos >= fill_r)) begin
      bad_ref_s = 1'b1;
    end else begin
      bad_ref_s = 1'b0;
    end
  end

  // History fill level (saturating) and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_r <= POS_W'(0);
      err    <= 1'b0;
    end else begin
      if (shift_en_s && (fill_r < POS_W'(SB_DEPTH))) begin
        fill_r <= fill_r + POS_W'(1);
      end
      if (accept_s && bad_ref_s) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// Scoreboard bench for lz77_decoder: stimulus pushes expected characters, a monitor pops them.
module tb_lz77_decoder;
  import lz77_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [POS_W-1:0]  code_pos = 4'd0;
  logic [LEN_W-1:0]  code_len = 3'd0;
  logic [CHAR_W-1:0] chardata = 8'h00;
  logic              out_valid;
  logic [CHAR_W-1:0] char_nxt;
  logic              encode;
  logic              finish;
`ifdef LZ77_DEC_CHK_EN
  logic              err;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  lz77_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_pos  (code_pos),
    .code_len  (code_len),
    .chardata  (chardata),
    .out_valid (out_valid),
    .char_nxt  (char_nxt),
    .encode    (encode),
    .finish    (finish)
`ifdef LZ77_DEC_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented character must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h, required no output at %0t", char_nxt, $time);
      end else begin
        check("stream", {24'h0, char_nxt}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'h0, in_ready}, 32'h1);
    code_pos = p;
    code_len = l;
    chardata = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'h0);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_char_nxt", {24'h0, char_nxt}, 32'h0);
    check("rst_finish", {31'h0, finish}, 32'h0);
    check("rst_encode", {31'h0, encode}, 32'h0);
`ifdef LZ77_DEC_CHK_EN
    check("rst_err", {31'h0, err}, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1 check("rel_in_ready", {31'h0, in_ready}, 32'h1);

    // 2: literal only, with latency
    exp_q.push_back("a");
    send(4'd0, 3'd0, "a");
    @(negedge clk) check("lat_pre", {31'h0, out_valid}, 32'h0);
    @(negedge clk) check("lat_hit", {31'h0, out_valid}, 32'h1);
    @(negedge clk) check("lat_post", {31'h0, out_valid}, 32'h0);
    drain();

    // 3: overlapping copy
    exp_q.push_back("a");
    repeat (3) exp_q.push_back("a");
    exp_q.push_back("b");
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd3, "b");
    drain();

    // 4: offset copy
    exp_q.push_back("a"); exp_q.push_back("b"); exp_q.push_back("c");
    exp_q.push_back("a"); exp_q.push_back("b"); exp_q.push_back("d");
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd0, "b");
    send(4'd0, 3'd0, "c");
    send(4'd2, 3'd2, "d");
    drain();

    // clamp: history oldest..newest = a,a,b,a,b,c,a,b,d
    exp_q.push_back("a"); exp_q.push_back("e");
    send(4'd15, 3'd1, "e");
    exp_q.push_back("b"); exp_q.push_back("a"); exp_q.push_back("f");
    send(4'd8, 3'd2, "f");
    drain();

    // 5: EOF
    exp_q.push_back("x"); exp_q.push_back("y");
    exp_q.push_back("y"); exp_q.push_back("y"); exp_q.push_back(8'h24);
    send(4'd0, 3'd0, "x");
    send(4'd0, 3'd0, "y");
    send(4'd0, 3'd2, 8'h24);
    drain();
    check("eof_finish", {31'h0, finish}, 32'h1);
    check("eof_in_ready", {31'h0, in_ready}, 32'h0);
    code_pos = 4'd0; code_len = 3'd0; chardata = "w";
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("done_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    check("done_finish_sticky", {31'h0, finish}, 32'h1);

    // 6: reset mid-COPY
    pulse_reset();
    check("rst2_finish", {31'h0, finish}, 32'h0);
    repeat (3) exp_q.push_back(8'hFF);
    send(4'd0, 3'd7, "z");
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_char_nxt", {24'h0, char_nxt}, 32'h0);
    check("midrst_q", exp_q.size(), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'hFF); exp_q.push_back("q");
    send(4'd0, 3'd1, "q");
    drain();

    // 7: reference past the history
    pulse_reset();
    exp_q.push_back("m"); exp_q.push_back("n");
    exp_q.push_back(8'hFF); exp_q.push_back("k");
    send(4'd0, 3'd0, "m");
    send(4'd0, 3'd0, "n");
`ifdef LZ77_DEC_CHK_EN
    @(negedge clk);
    check("err_before", {31'h0, err}, 32'h0);
`endif
    send(4'd5, 3'd1, "k");
    drain();
`ifdef LZ77_DEC_CHK_EN
    check("err_set", {31'h0, err}, 32'h1);
    exp_q.push_back("g");
    send(4'd0, 3'd0, "g");
    drain();
    check("err_sticky", {31'h0, err}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
